// File: rtl/sr_serializer_pkg.sv
// Shared definitions for the serial shift stage: state encoding, default
// geometry and a width helper.
package sr_serializer_pkg;

    localparam int unsigned SR_WIDTH_DEF = 8;
    localparam int unsigned SR_DIV_DEF   = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_TAIL = 2'd3;

    // Bits needed to count 0..v-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// DIV-cycle phase counter: tc_c pulses on the last cycle of each enabled
// phase, and the count wraps to zero so the next phase starts aligned.
module sr_phase_timer
    import sr_serializer_pkg::*;
#(
    parameter int unsigned DIV = SR_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc_c
);

    localparam int unsigned   PW   = clog2_min1(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tc_c = en && (cnt_q == LAST);

    // Next count: clear on a new word, advance and wrap while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc_c ? '0 : cnt_q + PW'(1);
        end
    end

    // Phase count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sr_serializer.sv
// Parallel-to-serial shift stage driving an external shift-register chain.
// Optional macro SR_LSB_FIRST_EN: shift i_data[0] first (default MSB first).
module sr_serializer
    import sr_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = SR_WIDTH_DEF,
    parameter int unsigned DIV   = SR_DIV_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_load,
    output logic             o_rdy,
    output logic             o_sclk,
    output logic             o_sdata
);

    localparam int unsigned BW = $clog2(WIDTH);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [BW-1:0]    bit_q;
    logic [BW-1:0]    bit_d;
    logic             load_c;
    logic             phase_en_c;
    logic             tc_c;

    assign phase_en_c = (state_q == ST_LOW) || (state_q == ST_HIGH);

    sr_phase_timer #(
        .DIV (DIV)
    ) u_phase_timer (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .en    (phase_en_c),
        .clr   (load_c),
        .tc_c  (tc_c)
    );

    // Outputs are pure decodes of registered state, so reset clears them at once.
    assign o_rdy  = (state_q == ST_IDLE);
    assign o_sclk = (state_q == ST_HIGH);
`ifdef SR_LSB_FIRST_EN
    assign o_sdata = sr_q[0];
`else
    assign o_sdata = sr_q[WIDTH-1];
`endif

    // Next-state, shift and bit-count logic.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        load_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    load_c  = 1'b1;
                    sr_d    = i_data;
                    bit_d   = BW'(WIDTH - 1);
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tc_c) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tc_c) begin
                    if (bit_q == '0) begin
                        state_d = ST_TAIL;
                    end else begin
                        bit_d   = bit_q - BW'(1);
`ifdef SR_LSB_FIRST_EN
                        sr_d    = {1'b0, sr_q[WIDTH-1:1]};
`else
                        sr_d    = {sr_q[WIDTH-2:0], 1'b0};
`endif
                        state_d = ST_LOW;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shift register and bit counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
        end
    end

endmodule

// File: tb/tb_sr_serializer.sv
// Directed bench for sr_serializer: a default 8-bit/DIV=2 instance and a
// 4-bit/DIV=1 instance sharing clock and reset.
module tb_sr_serializer;

`ifdef SR_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] data_a;
    logic       load_a;
    logic       rdy_a, sclk_a, sdata_a;
    logic [3:0] data_b;
    logic       load_b;
    logic       rdy_b, sclk_b, sdata_b;

    int n_checks;
    int n_pass;

    logic       bits_a[$];
    logic       bits_b[$];
    logic       prev_a, prev_b;
    int         busy_a, busy_b;
    logic [15:0] pat_b;

    sr_serializer #(.WIDTH(8), .DIV(2)) u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (data_a),
        .i_load  (load_a),
        .o_rdy   (rdy_a),
        .o_sclk  (sclk_a),
        .o_sdata (sdata_a)
    );

    sr_serializer #(.WIDTH(4), .DIV(1)) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (data_b),
        .i_load  (load_b),
        .o_rdy   (rdy_b),
        .o_sclk  (sclk_b),
        .o_sdata (sdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture a data bit at each sclk rise; count busy cycles; log sclk of B.
    always @(negedge clk) begin
        if (sclk_a && !prev_a) bits_a.push_back(sdata_a);
        if (sclk_b && !prev_b) bits_b.push_back(sdata_b);
        prev_a = sclk_a;
        prev_b = sclk_b;
        if (!rdy_a) busy_a = busy_a + 1;
        if (!rdy_b) begin
            busy_b = busy_b + 1;
            pat_b  = {pat_b[14:0], sclk_b};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Rebuild an 8-bit word from captured bits in shift order.
    function automatic logic [31:0] pack_a(input int start);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (start + i < bits_a.size()) begin
                if (LSB_FIRST) w[i] = bits_a[start + i];
                else           w[7 - i] = bits_a[start + i];
            end
        end
        return w;
    endfunction

    task automatic wait_idle_a(input string tag);
        int n;
        n = 0;
        while (!rdy_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(rdy_a), 32'd1);
    endtask

    task automatic clear_a();
        bits_a.delete();
        busy_a = 0;
    endtask

    task automatic word_a(input string tag, input logic [7:0] d);
        clear_a();
        @(negedge clk);
        load_a = 1'b1;
        data_a = d;
        @(negedge clk);
        load_a = 1'b0;
        wait_idle_a({tag, "_done"});
        check({tag, "_nbits"}, 32'(bits_a.size()), 32'd8);
        check({tag, "_word"}, pack_a(0), 32'(d));
        check({tag, "_busy"}, 32'(busy_a), 32'd33);
    endtask

    initial begin
        logic [3:0] wb;
        int n;
        n_checks = 0;
        n_pass   = 0;
        busy_a   = 0;
        busy_b   = 0;
        pat_b    = '0;
        prev_a   = 1'b0;
        prev_b   = 1'b0;
        rst_n    = 1'b0;
        load_a   = 1'b0;
        load_b   = 1'b0;
        data_a   = '0;
        data_b   = '0;

        #3;
        check("rst_rdy_a",   32'(rdy_a),   32'd1);
        check("rst_sclk_a",  32'(sclk_a),  32'd0);
        check("rst_sdata_a", 32'(sdata_a), 32'd0);
        check("rst_rdy_b",   32'(rdy_b),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single word at defaults.
        word_a("a5", 8'hA5);

        // Load strobe while busy must be ignored.
        clear_a();
        @(negedge clk);
        load_a = 1'b1;
        data_a = 8'h00;
        @(negedge clk);
        load_a = 1'b0;
        repeat (9) @(negedge clk);
        load_a = 1'b1;
        data_a = 8'hFF;
        @(negedge clk);
        load_a = 1'b0;
        wait_idle_a("busy_done");
        check("busy_nbits", 32'(bits_a.size()), 32'd8);
        check("busy_word",  pack_a(0), 32'h00);
        check("busy_busy",  32'(busy_a), 32'd33);
        repeat (3) @(negedge clk);
        check("busy_no_reload", 32'(rdy_a), 32'd1);

        // Back-to-back with load held high.
        clear_a();
        @(negedge clk);
        load_a = 1'b1;
        data_a = 8'h81;
        @(negedge clk);
        data_a = 8'h3C;
        wait_idle_a("b2b_gap");
        @(negedge clk);
        load_a = 1'b0;
        check("b2b_second_start", 32'(rdy_a), 32'd0);
        wait_idle_a("b2b_done");
        check("b2b_nbits", 32'(bits_a.size()), 32'd16);
        check("b2b_word0", pack_a(0), 32'h81);
        check("b2b_word1", pack_a(8), 32'h3C);
        check("b2b_busy",  32'(busy_a), 32'd66);

        // Reset mid-word, then a full fresh word.
        clear_a();
        @(negedge clk);
        load_a = 1'b1;
        data_a = 8'hF0;
        @(negedge clk);
        load_a = 1'b0;
        n = 0;
        while (bits_a.size() < 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("mid_3bits", 32'(bits_a.size()), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rdy",   32'(rdy_a),   32'd1);
        check("mid_rst_sclk",  32'(sclk_a),  32'd0);
        check("mid_rst_sdata", 32'(sdata_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        word_a("after_rst", 8'h0F);

        // Narrow, fastest instance.
        bits_b.delete();
        busy_b = 0;
        pat_b  = '0;
        @(negedge clk);
        load_b = 1'b1;
        data_b = 4'h6;
        @(negedge clk);
        load_b = 1'b0;
        n = 0;
        while (!rdy_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b_done",  32'(rdy_b), 32'd1);
        check("b_nbits", 32'(bits_b.size()), 32'd4);
        wb = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < bits_b.size()) begin
                if (LSB_FIRST) wb[i] = bits_b[i];
                else           wb[3 - i] = bits_b[i];
            end
        end
        check("b_word", 32'(wb), 32'h6);
        check("b_busy", 32'(busy_b), 32'd9);
        check("b_sclk_pattern", 32'(pat_b), 32'h00AA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
